// File: rtl/xmac_pkg.sv
// xmac_pkg: constants shared by the XMAC sequencer and its accumulator.
//   - ALU select codes (same values as the Atom ALU define header)
//   - XMAC request op codes
//   - sequencer FSM state encoding
package xmac_pkg;

  // ALU select codes
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_X_MUL = 4'hC;
  localparam logic [3:0] ALU_X_ADD = 4'hD;

  // Request op codes; 2'b11 is reserved and handled as RD
  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  typedef logic [1:0] xmac_state_t;

  // FSM state encoding
  localparam xmac_state_t ST_IDLE = 2'd0;
  localparam xmac_state_t ST_MUL  = 2'd1;
  localparam xmac_state_t ST_ADD  = 2'd2;
  localparam xmac_state_t ST_RESP = 2'd3;

endpackage

// File: rtl/xmac_acc_reg.sv
// xmac_acc_reg: 32-bit MAC accumulator register.
//   clk, rst   : clock, asynchronous active-high reset (acc <= ACC_RST)
//   clr        : acc <= ACC_RST (and clears the saturation flag)
//   load       : acc <= load_val (ADD pass result)
//   load_val   : value from the ALU X_ADD pass
//   acc        : current accumulator value
//   sat        : sticky saturation flag (only with XMAC_SATURATE_EN)
// Macro XMAC_SATURATE_EN: saturate at 32'hFFFFFFFF instead of wrapping.
module xmac_acc_reg #(
  parameter logic [31:0] ACC_RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_val,
`ifdef XMAC_SATURATE_EN
  output logic        sat,
`endif
  output logic [31:0] acc
);

`ifdef XMAC_SATURATE_EN
  // A sum smaller than the old accumulator means the unsigned add wrapped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= ACC_RST;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= ACC_RST;
      sat <= 1'b0;
    end else if (load) begin
      if (load_val < acc) begin
        acc <= '1;
        sat <= 1'b1;
      end else begin
        acc <= load_val;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= ACC_RST;
    end else if (clr) begin
      acc <= ACC_RST;
    end else if (load) begin
      acc <= load_val;
    end
  end
`endif

endmodule

// File: rtl/xmac_sequencer.sv
// xmac_sequencer: multiply-accumulate controller built from two Atom ALU
// passes (X_MUL then X_ADD against an internal accumulator).
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o : request handshake
//   req_op_i, req_a_i       : op (MAC/CLR/RD, 2'b11 as RD), MAC operand
//   alu_a_o/alu_b_o/alu_sel_o, alu_out_i : borrowed ALU interface
//   alu_busy_o              : sequencer drives the ALU this cycle
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_data_o              : accumulator value after the op
//   sat_o                   : sticky saturation flag (XMAC_SATURATE_EN only)
// Macro XMAC_SATURATE_EN: saturating accumulator plus sat_o port.
module xmac_sequencer
  import xmac_pkg::*;
#(
  parameter logic [31:0] ACC_RST = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_a_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_sel_o,
  input  logic [31:0] alu_out_i,
  output logic        alu_busy_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
`ifdef XMAC_SATURATE_EN
  output logic        sat_o,
`endif
  output logic [31:0] rsp_data_o
);

  xmac_state_t state;
  logic [31:0] opnd;
  logic [31:0] prod;
  logic [31:0] acc;
  logic        accept;
  logic        acc_clr;
  logic        acc_load;

  assign accept   = req_valid_i && (state == ST_IDLE);
  assign acc_clr  = accept && (req_op_i == OP_CLR);
  assign acc_load = (state == ST_ADD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      opnd  <= '0;
      prod  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (req_op_i == OP_MAC) begin
              opnd  <= req_a_i;
              state <= ST_MUL;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_MUL: begin
          prod  <= alu_out_i;
          state <= ST_ADD;
        end
        ST_ADD: begin
          state <= ST_RESP;
        end
        default: begin
          if (rsp_ready_i) state <= ST_IDLE;
        end
      endcase
    end
  end

  xmac_acc_reg #(
    .ACC_RST (ACC_RST)
  ) u_acc (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (acc_clr),
    .load     (acc_load),
    .load_val (alu_out_i),
`ifdef XMAC_SATURATE_EN
    .sat      (sat_o),
`endif
    .acc      (acc)
  );

  // ALU drive is decoded from state and internal registers only, so no
  // combinational path exists from req_* to the ALU.
  always_comb begin
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_sel_o  = ALU_ADD;
    alu_busy_o = 1'b0;
    case (state)
      ST_MUL: begin
        alu_busy_o = 1'b1;
        alu_sel_o  = ALU_X_MUL;
        alu_a_o    = opnd;
      end
      ST_ADD: begin
        alu_busy_o = 1'b1;
        alu_sel_o  = ALU_X_ADD;
        alu_a_o    = prod;
        alu_b_o    = acc;
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_data_o  = acc;

endmodule

// File: tb/tb_xmac_sequencer.sv
// Testbench for xmac_sequencer with a behavioural ALU stub
// (X_MUL = A[15:0]*A[15:0], X_ADD = A+B).
module tb_xmac_sequencer;
  import xmac_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = OP_RD;
  logic [31:0] req_a = '0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_busy;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
`ifdef XMAC_SATURATE_EN
  logic        sat;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    logic [31:0] m;
    m = {16'd0, alu_a[15:0]};
    case (alu_sel)
      ALU_X_MUL: alu_out = m * m;
      ALU_X_ADD: alu_out = alu_a + alu_b;
      ALU_ADD:   alu_out = alu_a + alu_b;
      default:   alu_out = '0;
    endcase
  end

  xmac_sequencer #(
    .ACC_RST (32'd0)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_sel_o   (alu_sel),
    .alu_out_i   (alu_out),
    .alu_busy_o  (alu_busy),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
`ifdef XMAC_SATURATE_EN
    .sat_o       (sat),
`endif
    .rsp_data_o  (rsp_data)
  );

  // One request/response transaction with rsp_ready held high.
  // lat = cycles from accept to rsp_valid (-1 on timeout).
  task automatic xact(input logic [1:0] op, input logic [31:0] a,
                      output int lat, output logic [31:0] data,
                      output int busy_cnt, output logic [3:0] sel0,
                      output logic [3:0] sel1);
    int k;
    lat = 0; busy_cnt = 0; data = 'x; sel0 = '0; sel1 = '0;
    @(negedge clk);
    rsp_ready = 1'b1; req_op = op; req_a = a; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (alu_busy) begin
        if (busy_cnt == 0) sel0 = alu_sel; else sel1 = alu_sel;
        busy_cnt++;
      end
      if (rsp_valid) begin data = rsp_data; break; end
    end
    if (!rsp_valid) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat, bc; logic [31:0] d; logic [3:0] s0, s1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (alu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_alu_busy got=%b exp=0", alu_busy); end
    n_checks++; if (alu_sel !== ALU_ADD || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_fail++; $display("FAIL rst_alu_outs sel=%h a=%h b=%h exp 0/0/0", alu_sel, alu_a, alu_b); end
    n_checks++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
    @(negedge clk); rst = 1'b0;
    xact(OP_RD, 32'd0, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rd_data got=%h exp=0", d); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rd_latency got=%0d exp=1", lat); end
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL rd_busy_cycles got=%0d exp=0", bc); end
  endtask

  task automatic test_mac();
    int lat, bc; logic [31:0] d; logic [3:0] s0, s1;
    xact(OP_MAC, 32'd3, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'd9) begin n_fail++; $display("FAIL mac3_data got=%h exp=9", d); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL mac3_latency got=%0d exp=3", lat); end
    n_checks++; if (bc !== 2) begin n_fail++; $display("FAIL mac3_busy_cycles got=%0d exp=2", bc); end
    n_checks++; if (s0 !== ALU_X_MUL || s1 !== ALU_X_ADD) begin
      n_fail++; $display("FAIL mac3_sel_seq got=%h,%h exp=%h,%h", s0, s1, ALU_X_MUL, ALU_X_ADD); end
    xact(OP_MAC, 32'd5, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'd34) begin n_fail++; $display("FAIL mac5_data got=%h exp=22", d); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL mac5_latency got=%0d exp=3", lat); end
    n_checks++; if (bc !== 2) begin n_fail++; $display("FAIL mac5_busy_cycles got=%0d exp=2", bc); end
    // reserved op behaves as RD
    xact(2'b11, 32'd9, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'd34 || lat !== 1) begin
      n_fail++; $display("FAIL rsvd_as_rd data=%h lat=%0d exp 22/1", d, lat); end
  endtask

  task automatic test_saturate();
    int lat, bc; logic [31:0] d; logic [3:0] s0, s1;
    logic [31:0] exp_wrap;
    xact(OP_CLR, 32'd0, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'd0 || lat !== 1) begin
      n_fail++; $display("FAIL clr_data data=%h lat=%0d exp 0/1", d, lat); end
    // 0xFFFE0001 + 362^2 + 3^2 + 1 + 1 = 0xFFFFFFF0
    xact(OP_MAC, 32'h0000FFFF, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'hFFFE0001) begin n_fail++; $display("FAIL preload1 got=%h exp=fffe0001", d); end
    xact(OP_MAC, 32'd362, lat, d, bc, s0, s1);
    xact(OP_MAC, 32'd3, lat, d, bc, s0, s1);
    xact(OP_MAC, 32'd1, lat, d, bc, s0, s1);
    xact(OP_MAC, 32'd1, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL preload_final got=%h exp=fffffff0", d); end
    xact(OP_MAC, 32'hABCDFFFF, lat, d, bc, s0, s1);
`ifdef XMAC_SATURATE_EN
    exp_wrap = 32'hFFFFFFFF;
    n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_set got=%b exp=1", sat); end
`else
    exp_wrap = 32'hFFFDFFF1;
`endif
    n_checks++; if (d !== exp_wrap) begin n_fail++; $display("FAIL overflow_acc got=%h exp=%h", d, exp_wrap); end
    xact(OP_CLR, 32'd0, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL clr_after_ovf got=%h exp=0", d); end
`ifdef XMAC_SATURATE_EN
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL sat_clear got=%b exp=0", sat); end
`endif
  endtask

  task automatic test_backpressure();
    int k;
    @(negedge clk);
    rsp_ready = 1'b0; req_op = OP_MAC; req_a = 32'd2; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_timeout rsp_valid=%b exp=1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd4 || req_ready !== 1'b0 || alu_busy !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d] valid=%b data=%h ready=%b busy=%b exp 1/4/0/0",
                           i, rsp_valid, rsp_data, req_ready, alu_busy); end
      if (i == 1) begin req_op = OP_CLR; req_valid = 1'b1; end
      if (i == 2) req_valid = 1'b0;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd4) begin
        n_fail++; $display("FAIL bp_ignored_req[%0d] valid=%b data=%h exp 0/4", i, rsp_valid, rsp_data); end
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc; logic [31:0] d; logic [3:0] s0, s1;
    @(negedge clk);
    rsp_ready = 1'b1; req_op = OP_MAC; req_a = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);  // MUL
    @(negedge clk);  // ADD
    n_checks++; if (alu_busy !== 1'b1 || alu_sel !== ALU_X_ADD || alu_a !== 32'd49 || alu_b !== 32'd4) begin
      n_fail++; $display("FAIL abort_in_add busy=%b sel=%h a=%h b=%h exp 1/%h/31/4",
                         alu_busy, alu_sel, alu_a, alu_b, ALU_X_ADD); end
    rst = 1'b1;
    #1;
    n_checks++; if (alu_busy !== 1'b0 || alu_sel !== ALU_ADD || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_fail++; $display("FAIL abort_alu busy=%b sel=%h a=%h b=%h exp 0/0/0/0", alu_busy, alu_sel, alu_a, alu_b); end
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
      n_fail++; $display("FAIL abort_hs ready=%b valid=%b data=%h exp 1/0/0", req_ready, rsp_valid, rsp_data); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    xact(OP_RD, 32'd0, lat, d, bc, s0, s1);
    n_checks++; if (d !== 32'd0 || lat !== 1) begin
      n_fail++; $display("FAIL abort_rd data=%h lat=%0d exp 0/1", d, lat); end
  endtask

  initial begin
    test_reset();
    test_mac();
    test_saturate();
    test_backpressure();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
